// File: rtl/soc_pio_pkg.sv
// Shared constants for the SoC parallel input port: register map and edge-type encoding.
package soc_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  typedef enum logic [1:0] {
    RISE = 2'd0,
    FALL = 2'd1,
    ANY  = 2'd2
  } edge_type_e;

endpackage

// File: rtl/pio_bit_filter.sv
// One input pin: synchroniser chain followed by a hold-time debounce filter.
module pio_bit_filter
  import soc_pio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic filt
);

  localparam int unsigned D  = (DEBOUNCE == 0) ? 1 : DEBOUNCE;
  localparam int unsigned CW = $clog2(D + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(D - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   filt_q, filt_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  assign sync = sync_q[SYNC_STAGES-1];
  assign filt = filt_q;

  // The counter only advances while the synchronised level disagrees with
  // the accepted one; any return to agreement restarts the hold window.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/soc_pio_in_capture.sv
// Avalon-MM input port: per-pin filtering, sticky edge capture (W1C) and masked level irq.
module soc_pio_in_capture
  import soc_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 0,
  parameter int unsigned EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam edge_type_e EDGE_SEL = edge_type_e'(EDGE_TYPE[1:0]);

  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] filt_dly_q;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rdata_q, rdata_d;
  logic             wr_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_bit_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE   (DEBOUNCE)
    ) u_filt (
      .clk  (clk),
      .reset(reset),
      .din  (in_port[i]),
      .filt (filt[i])
    );
  end

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    edges = '0;
    unique case (EDGE_SEL)
      RISE:    edges = filt & ~filt_dly_q;
      FALL:    edges = ~filt & filt_dly_q;
      default: edges = filt ^ filt_dly_q;
    endcase
  end

  always_comb begin
    mask_d = mask_q;
    clr    = '0;
    if (wr_en && (address == PIO_ADDR_IRQMASK)) begin
      mask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == PIO_ADDR_EDGECAP)) begin
      clr = writedata[WIDTH-1:0];
    end
    // New edges are OR-ed in after the clear so a coincident set survives.
    cap_d = (cap_q & ~clr) | edges;
  end

  always_comb begin
    rdata_d = '0;
    unique case (address)
      PIO_ADDR_DATA:    rdata_d[WIDTH-1:0] = filt;
      PIO_ADDR_RSVD:    rdata_d = '0;
      PIO_ADDR_IRQMASK: rdata_d[WIDTH-1:0] = mask_q;
      PIO_ADDR_EDGECAP: rdata_d[WIDTH-1:0] = cap_q;
      default:          rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_dly_q <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      rdata_q    <= '0;
    end else begin
      filt_dly_q <= filt;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      rdata_q    <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_soc_pio_in_capture.sv
// Scoreboard bench for soc_pio_in_capture across four parameter sets sharing one slave bus.
module tb_soc_pio_in_capture;

  typedef struct {
    int unsigned dut;
    logic [31:0] data;
    logic        irq;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic [3:0]  cs = '0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;

  logic [7:0]  in0 = '0, in1 = '0, in2 = '0;
  logic [2:0]  in3 = '0;
  logic [31:0] rdata0, rdata1, rdata2, rdata3;
  logic        irq0, irq1, irq2, irq3;

  exp_t        sb[$];
  logic        rd_pend = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  soc_pio_in_capture #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE(0), .EDGE_TYPE(0)) u_dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs[0]), .write_n(write_n),
    .writedata(writedata), .in_port(in0), .readdata(rdata0), .irq(irq0));

  soc_pio_in_capture #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE(4), .EDGE_TYPE(0)) u_dut1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs[1]), .write_n(write_n),
    .writedata(writedata), .in_port(in1), .readdata(rdata1), .irq(irq1));

  soc_pio_in_capture #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE(0), .EDGE_TYPE(1)) u_dut2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs[2]), .write_n(write_n),
    .writedata(writedata), .in_port(in2), .readdata(rdata2), .irq(irq2));

  soc_pio_in_capture #(.WIDTH(3), .SYNC_STAGES(2), .DEBOUNCE(0), .EDGE_TYPE(2)) u_dut3 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs[3]), .write_n(write_n),
    .writedata(writedata), .in_port(in3), .readdata(rdata3), .irq(irq3));

  // A read issued before a rising edge has its data on readdata after that edge.
  always @(posedge clk) rd_pend <= (cs != 4'b0) && write_n;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: read completed with no expectation queued");
      end else begin
        exp_t        e;
        logic [31:0] act_d;
        logic        act_i;
        e = sb.pop_front();
        case (e.dut)
          0:       begin act_d = rdata0; act_i = irq0; end
          1:       begin act_d = rdata1; act_i = irq1; end
          2:       begin act_d = rdata2; act_i = irq2; end
          default: begin act_d = rdata3; act_i = irq3; end
        endcase
        n_checks++;
        if (act_d !== e.data) begin
          n_fail++;
          $display("FAIL %s readdata dut%0d: got 0x%08h expected 0x%08h", e.name, e.dut, act_d, e.data);
        end
        n_checks++;
        if (act_i !== e.irq) begin
          n_fail++;
          $display("FAIL %s irq dut%0d: got %0b expected %0b", e.name, e.dut, act_i, e.irq);
        end
      end
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input int unsigned d, input logic [1:0] a, input logic [31:0] ed,
                    input logic ei, input string nm);
    cs      = 4'(1) << d;
    write_n = 1'b1;
    address = a;
    sb.push_back('{d, ed, ei, nm});
    @(negedge clk);
    cs = '0;
  endtask

  task automatic wr(input int unsigned d, input logic [1:0] a, input logic [31:0] v);
    cs        = 4'(1) << d;
    write_n   = 1'b0;
    address   = a;
    writedata = v;
    @(negedge clk);
    cs      = '0;
    write_n = 1'b1;
  endtask

  task automatic do_reset();
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle(2);
    // Reset state
    rd(0, 2'd0, 32'h0, 1'b0, "rst_during");
    idle(1);
    reset = 1'b0;
    rd(0, 2'd2, 32'h0, 1'b0, "rst_mask");
    rd(0, 2'd3, 32'h0, 1'b0, "rst_cap");
    rd(0, 2'd0, 32'h0, 1'b0, "rst_data");

    // Basic capture, default parameters
    wr(0, 2'd2, 32'h04);
    in0 = 8'h05;
    rd(0, 2'd3, 32'h00, 1'b0, "cap_e1");
    rd(0, 2'd3, 32'h00, 1'b0, "cap_e2");
    rd(0, 2'd3, 32'h00, 1'b0, "cap_e3");
    rd(0, 2'd3, 32'h00, 1'b1, "cap_e4");
    rd(0, 2'd3, 32'h05, 1'b1, "cap_e5");
    rd(0, 2'd3, 32'h05, 1'b1, "cap_sticky");
    rd(0, 2'd0, 32'h05, 1'b1, "data");
    wr(0, 2'd3, 32'h04);
    rd(0, 2'd3, 32'h01, 1'b0, "w1c");
    rd(0, 2'd2, 32'h04, 1'b0, "mask_rb");
    wr(0, 2'd1, 32'hFF);
    rd(0, 2'd1, 32'h00, 1'b0, "rsvd");
    wr(0, 2'd0, 32'hFF);
    rd(0, 2'd0, 32'h05, 1'b0, "data_ro");

    // W1C of bit 3 lands on the same edge that captures bit 3
    in0 = 8'h0D;
    idle(3);
    wr(0, 2'd3, 32'h09);
    rd(0, 2'd3, 32'h08, 1'b0, "collide");
    wr(0, 2'd2, 32'h08);
    rd(0, 2'd3, 32'h08, 1'b1, "irq_mask8");
    wr(0, 2'd3, 32'h08);
    rd(0, 2'd3, 32'h00, 1'b0, "irq_clr");

    // Debounce = 4
    do_reset();
    wr(1, 2'd2, 32'h01);
    in1 = 8'h01;
    rd(1, 2'd0, 32'h0, 1'b0, "db_pulse");
    rd(1, 2'd0, 32'h0, 1'b0, "db_pulse");
    rd(1, 2'd0, 32'h0, 1'b0, "db_pulse");
    in1 = 8'h00;
    for (int k = 0; k < 6; k++) rd(1, 2'd0, 32'h0, 1'b0, "db_pulse_tail");
    rd(1, 2'd3, 32'h0, 1'b0, "db_glitch_cap");
    in1 = 8'h01;
    for (int k = 1; k <= 8; k++)
      rd(1, 2'd0, (k >= 7) ? 32'h1 : 32'h0, (k >= 7), "db_hold");
    rd(1, 2'd3, 32'h1, 1'b1, "db_cap");

    // Reset in the middle of a debounce window
    in1 = 8'h00;
    idle(10);
    wr(1, 2'd3, 32'hFF);
    rd(1, 2'd3, 32'h0, 1'b0, "db_cleared");
    in1 = 8'h01;
    idle(4);
    reset = 1'b1;
    in1 = 8'h00;
    idle(1);
    reset = 1'b0;
    idle(8);
    rd(1, 2'd3, 32'h0, 1'b0, "rst_mid_cap");
    rd(1, 2'd0, 32'h0, 1'b0, "rst_mid_data");

    // Falling-edge capture
    do_reset();
    in2 = 8'hFF;
    idle(8);
    rd(2, 2'd3, 32'h00, 1'b0, "fall_rise_ign");
    in2 = 8'h7F;
    rd(2, 2'd3, 32'h00, 1'b0, "fall_e1");
    rd(2, 2'd3, 32'h00, 1'b0, "fall_e2");
    rd(2, 2'd3, 32'h00, 1'b0, "fall_e3");
    rd(2, 2'd3, 32'h00, 1'b0, "fall_e4");
    rd(2, 2'd3, 32'h80, 1'b0, "fall_e5");
    wr(2, 2'd2, 32'h80);
    rd(2, 2'd3, 32'h80, 1'b1, "fall_irq");
    in2 = 8'hFF;
    idle(6);
    rd(2, 2'd3, 32'h80, 1'b1, "fall_no_new");
    rd(2, 2'd0, 32'hFF, 1'b1, "fall_data");

    // WIDTH=3, any-edge; pin high while reset is released
    reset = 1'b1;
    in3 = 3'h1;
    idle(2);
    reset = 1'b0;
    idle(6);
    rd(3, 2'd3, 32'h1, 1'b0, "rst_high_cap");
    wr(3, 2'd3, 32'hFFFFFFFF);
    in3 = 3'h7;
    idle(6);
    rd(3, 2'd0, 32'h00000007, 1'b0, "w3_data");
    rd(3, 2'd3, 32'h6, 1'b0, "w3_cap");
    wr(3, 2'd3, 32'h7);
    in3 = 3'h5;
    idle(6);
    rd(3, 2'd3, 32'h2, 1'b0, "any_fall");
    wr(3, 2'd2, 32'hFFFFFFFF);
    rd(3, 2'd2, 32'h7, 1'b1, "w3_mask");

    idle(3);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
